uart_access_ctrl: RTL and testbench
===================================

// Module: uart_access_ctrl
// PURPOSE
//  Sequences the COREUART CPU-style port (CSN/WEN/OEN strobes, TXRDY/RXRDY polling).
//  Round-robins two TX byte-stream requesters onto the UART, drains RX bytes into a
//  valid/ready stream, and keeps sticky error status. Sits between the UART and the
//  bridge command engine, and is the only master of the UART strobes.
// PARAMETERS
//  GUARD_CYCLES  2  idle cycles after each strobe before TXRDY/RXRDY are re-sampled (1..7)
//  CNT_W         16 width of the TX/RX byte counters
// PORTS
//  CLK              in   1      system clock, shared with the UART
//  RESET_N          in   1      asynchronous active-low reset
//  req0_valid/ready in/out 1/1  TX requester 0 handshake
//  req0_data        in   8      TX requester 0 byte
//  req1_valid/ready in/out 1/1  TX requester 1 handshake
//  req1_data        in   8      TX requester 1 byte
//  rx_valid/ready   out/in 1/1  RX stream handshake
//  rx_data          out  8      received byte
//  rx_perr, rx_ferr out  1      parity/framing flag captured with rx_data
//  err_overflow     out  1      sticky UART OVERFLOW seen
//  err_clr          in   1      clears err_overflow
//  tx_count,rx_count out CNT_W  bytes written/read, wrap modulo 2^CNT_W
//  uart_csn,uart_wen,uart_oen out 1  UART strobes, active low
//  uart_wdata       out  8      to UART DATA_IN
//  uart_rdata       in   8      from UART DATA_OUT
//  uart_txrdy,uart_rxrdy,uart_perr,uart_ferr,uart_ovf in 1  UART status
// BEHAVIOUR
//  Reset: uart_csn/wen/oen=1, uart_wdata=0, req*_ready=0, rx_valid=0, rx_data=0,
//   rx_perr/ferr=0, err_overflow=0, counts=0, rr pointer=req0, state=IDLE.
//  FSM IDLE -> WRITE | READ; WRITE -> GUARD; READ -> GUARD; GUARD -> IDLE.
//  IDLE priority: READ if uart_rxrdy=1 and rx_valid=0 (RX first, limits overflow);
//   else WRITE if uart_txrdy=1 and any req*_valid; else stay.
//  TX arbitration: round-robin. Winner = rr pointer if its valid is set, else the other.
//   Pointer moves to the non-winner after each grant.
//  WRITE (1 cycle): uart_csn=0, uart_wen=0, uart_wdata=winner data (registered).
//   The winner's req_ready=1 in this same cycle only, so the transfer completes here.
//   tx_count+1.
//  READ (1 cycle): uart_csn=0, uart_oen=0. At the end of the cycle, capture uart_rdata,
//   uart_perr and uart_ferr into rx_data/rx_perr/rx_ferr. rx_valid=1 next cycle, rx_count+1.
//  GUARD: hold strobes high for GUARD_CYCLES cycles, driven by a 3-bit down-counter.
//   This covers the registered TXRDY/RXRDY update lag, so a single byte is never read or
//   written twice.
//  rx_valid stays high until rx_valid&rx_ready. It then drops on the next edge.
//   rx_data is stable while rx_valid=1. No READ is issued while rx_valid=1.
//  err_overflow: set on uart_ovf=1. If uart_ovf and err_clr occur in the same cycle, set wins.
//   Otherwise err_clr clears it.
//  Strobes are mutually exclusive: WEN and OEN are never low together, and CSN is low only
//   in WRITE/READ.
//  Minimum spacing between any two strobes is GUARD_CYCLES+1 cycles.
//  req*_data may change while the matching req*_valid=0. It must hold while valid=1.
//  Reset asserted mid-WRITE/READ: strobes return high immediately (async), and no partial
//   handshake is reported.
// STRUCTURE
//  Shared package uart_ctrl_pkg: state encoding (IDLE/WRITE/READ/GUARD), GUARD_CYCLES
//   default, and strobe-level localparams.
//  One sub-module, uart_rr_arb2: a 2-requester round-robin arbiter that outputs
//   grant/grant_idx and takes an advance input. Everything else is inline.
// TESTING
//  req0 sends 0x55 with txrdy=1 -> one cycle with csn=0,wen=0,wdata=0x55, req0_ready pulses
//   once, tx_count=1.
//  req0 and req1 both valid, 4 bytes each -> grants alternate 0,1,0,1..., each WRITE is
//   >=GUARD_CYCLES+1 apart.
//  rxrdy=1 with uart_rdata=0xA3 and txrdy=1 with req0 valid, same cycle -> READ first;
//   rx_data=0xA3 and rx_valid=1, then WRITE after the guard.
//  rx_ready=0 for 20 cycles with rxrdy=1 -> exactly one READ, rx_data held, no further oen
//   strobe until the handshake completes.
//  uart_ovf pulses while err_clr=1 -> err_overflow=1; err_clr next cycle -> 0.
//  Read with uart_perr=1 -> rx_perr=1 alongside the data. Reset mid-READ -> all outputs
//   at reset values.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Purpose : shared encodings for the COREUART access controller.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: FSM state encoding, default guard length, UART strobe levels.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  // Idle cycles after each strobe before UART status is trusted again.
  localparam int GUARD_CYCLES_DEF = 2;

  // UART strobes are active low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/uart_rr_arb2.sv
// Purpose : two-requester round-robin arbiter; the pointer favours the requester
//           that lost the previous grant.
// Latency : grant is combinational from i_req; pointer updates on the clock edge.
// Backpr. : grant holds until i_advance is pulsed with a request present.
// Ports   : clk, rst_n (async active-low), i_req[1:0], i_advance,
//           o_grant[1:0] (one-hot, zero when no request), o_grant_idx.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic r_ptr;
  logic w_idx;

  // Winner is the pointed-to requester if it is asking, otherwise the other one.
  always_comb begin
    w_idx = r_ptr;
    if (!i_req[r_ptr]) begin
      w_idx = ~r_ptr;
    end
    o_grant_idx = w_idx;
    o_grant     = 2'b00;
    if (|i_req) begin
      o_grant = w_idx ? 2'b10 : 2'b01;
    end
  end

  // After a grant the pointer moves to the non-winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_advance && (|i_req)) begin
      r_ptr <= ~w_idx;
    end
  end

endmodule

// File: rtl/uart_access_ctrl.sv
// Purpose : sole master of the COREUART CPU port; arbitrates two TX byte streams onto
//           the UART and drains RX bytes into a valid/ready stream with sticky errors.
// Latency : strobe one cycle after the IDLE decision; rx_valid one cycle after READ.
// Backpr. : req*_ready pulses only in the WRITE cycle; no READ while rx_valid is held.
// Ports   : CLK, RESET_N; req0/req1 valid/ready/data (TX in); rx_valid/ready/data,
//           rx_perr/rx_ferr (RX out); err_overflow/err_clr; tx_count/rx_count;
//           uart_csn/wen/oen/wdata (to UART); uart_rdata/txrdy/rxrdy/perr/ferr/ovf (from UART).
module uart_access_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  output logic             err_overflow,
  input  logic             err_clr,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic             uart_csn,
  output logic             uart_wen,
  output logic             uart_oen,
  output logic [7:0]       uart_wdata,
  input  logic [7:0]       uart_rdata,
  input  logic             uart_txrdy,
  input  logic             uart_rxrdy,
  input  logic             uart_perr,
  input  logic             uart_ferr,
  input  logic             uart_ovf
);

  // GUARD lasts GUARD_CYCLES cycles: load N-1 and leave when the counter hits zero.
  localparam logic [2:0] GUARD_LOAD = 3'(GUARD_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_gcnt;
  logic             w_do_read;
  logic             w_do_write;
  logic [1:0]       w_req;
  logic [1:0]       w_grant;
  logic             w_grant_idx;

  logic             r_csn;
  logic             r_wen;
  logic             r_oen;
  logic [7:0]       r_wdata;
  logic [1:0]       r_req_rdy;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             r_rx_perr;
  logic             r_rx_ferr;
  logic             r_err_ovf;
  logic [CNT_W-1:0] r_tx_count;
  logic [CNT_W-1:0] r_rx_count;

  assign w_req = {req1_valid, req0_valid};

  uart_rr_arb2 u_arb (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_req       (w_req),
    .i_advance   (w_do_write),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Next-state: RX is served before TX so the UART receive buffer drains first.
  always_comb begin
    w_state_nxt = r_state;
    w_do_read   = 1'b0;
    w_do_write  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (uart_rxrdy && !r_rx_valid) begin
          w_do_read   = 1'b1;
          w_state_nxt = ST_READ;
        end else if (uart_txrdy && (|w_req)) begin
          w_do_write  = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: w_state_nxt = ST_GUARD;
      ST_READ:  w_state_nxt = ST_GUARD;
      ST_GUARD: begin
        if (r_gcnt == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_gcnt <= 3'd0;
    end else if (r_state == ST_WRITE || r_state == ST_READ) begin
      r_gcnt <= GUARD_LOAD;
    end else if (r_state == ST_GUARD && r_gcnt != 3'd0) begin
      r_gcnt <= r_gcnt - 3'd1;
    end
  end

  // Strobes and ready are registered alongside the state, so they are asserted
  // exactly during the WRITE/READ cycle and drop asynchronously on reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_csn     <= STROBE_OFF;
      r_wen     <= STROBE_OFF;
      r_oen     <= STROBE_OFF;
      r_wdata   <= 8'h00;
      r_req_rdy <= 2'b00;
    end else begin
      r_csn     <= (w_do_read || w_do_write) ? STROBE_ON : STROBE_OFF;
      r_wen     <= w_do_write ? STROBE_ON : STROBE_OFF;
      r_oen     <= w_do_read  ? STROBE_ON : STROBE_OFF;
      r_req_rdy <= w_do_write ? w_grant : 2'b00;
      if (w_do_write) begin
        r_wdata <= w_grant_idx ? req1_data : req0_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tx_count <= '0;
    end else if (r_state == ST_WRITE) begin
      r_tx_count <= r_tx_count + CNT_W'(1);
    end
  end

  // READ never starts while rx_valid is held, so capture and release cannot collide.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_count <= '0;
    end else if (r_state == ST_READ) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= uart_rdata;
      r_rx_perr  <= uart_perr;
      r_rx_ferr  <= uart_ferr;
      r_rx_count <= r_rx_count + CNT_W'(1);
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // A new overflow takes precedence over a clear in the same cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err_ovf <= 1'b0;
    end else if (uart_ovf) begin
      r_err_ovf <= 1'b1;
    end else if (err_clr) begin
      r_err_ovf <= 1'b0;
    end
  end

  assign uart_csn     = r_csn;
  assign uart_wen     = r_wen;
  assign uart_oen     = r_oen;
  assign uart_wdata   = r_wdata;
  assign req0_ready   = r_req_rdy[0];
  assign req1_ready   = r_req_rdy[1];
  assign rx_valid     = r_rx_valid;
  assign rx_data      = r_rx_data;
  assign rx_perr      = r_rx_perr;
  assign rx_ferr      = r_rx_ferr;
  assign err_overflow = r_err_ovf;
  assign tx_count     = r_tx_count;
  assign rx_count     = r_rx_count;

endmodule

// File: tb/tb_uart_access_ctrl.sv
// Purpose : self-checking bench for uart_access_ctrl; stimulus pushes expected TX/RX
//           bytes into queues and a negedge monitor pops and compares on each strobe
//           or RX handshake.
// Latency : n/a. Backpr.: rx_ready is held low in one scenario to stall the RX stream.
`timescale 1ns/1ps
module tb_uart_access_ctrl;

  localparam int G     = 2;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]       req0_data, req1_data;
  logic             rx_valid, rx_ready, rx_perr, rx_ferr;
  logic [7:0]       rx_data;
  logic             err_overflow, err_clr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             uart_csn, uart_wen, uart_oen;
  logic [7:0]       uart_wdata, uart_rdata;
  logic             uart_txrdy, uart_rxrdy, uart_perr, uart_ferr, uart_ovf;

  always #5 CLK = ~CLK;

  uart_access_ctrl #(.GUARD_CYCLES(G), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .err_overflow(err_overflow), .err_clr(err_clr),
    .tx_count(tx_count), .rx_count(rx_count),
    .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
    .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_perr(uart_perr), .uart_ferr(uart_ferr), .uart_ovf(uart_ovf)
  );

  typedef struct packed { logic idx; logic [7:0] d; } tx_exp_t;
  typedef struct packed { logic [7:0] d; logic pe; logic fe; } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  int      strobe_cyc[$];
  int      strobe_kind[$];   // 1 = write, 2 = read
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      last_strobe = -1000;
  int      n_reads = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  tx_exp_t    te;
  rx_exp_t    re;
  logic       prev_vld = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge CLK) begin
    cyc++;
    if (!RESET_N) begin
      last_strobe = -1000;
      prev_vld = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (!uart_wen || !uart_oen) begin
        chk("strobe_csn_low", uart_csn, 1'b0);
        chk("strobe_exclusive", (!uart_wen && !uart_oen), 1'b0);
        chk("strobe_spacing", ((cyc - last_strobe) >= G + 1), 1'b1);
        last_strobe = cyc;
        strobe_cyc.push_back(cyc);
        strobe_kind.push_back(!uart_wen ? 1 : 2);
      end else if (!uart_csn) begin
        chk("csn_without_strobe", uart_csn, 1'b1);
      end
      if (!uart_wen) begin
        chk("tx_expected", tx_q.size() != 0, 1'b1);
        if (tx_q.size() != 0) begin
          te = tx_q.pop_front();
          chk("tx_wdata", uart_wdata, te.d);
          chk("tx_req0_ready", req0_ready, (te.idx == 1'b0));
          chk("tx_req1_ready", req1_ready, (te.idx == 1'b1));
        end
      end else if (req0_ready || req1_ready) begin
        chk("ready_outside_write", {req1_ready, req0_ready}, 2'b00);
      end
      if (!uart_oen) n_reads++;
      if (rx_valid && prev_vld && !prev_hs) chk("rx_data_stable", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        chk("rx_expected", rx_q.size() != 0, 1'b1);
        if (rx_q.size() != 0) begin
          re = rx_q.pop_front();
          chk("rx_data", rx_data, re.d);
          chk("rx_perr", rx_perr, re.pe);
          chk("rx_ferr", rx_ferr, re.fe);
        end
      end
      prev_vld  = rx_valid;
      prev_data = rx_data;
      prev_hs   = rx_valid && rx_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic rdy_of(input int idx);
    return (idx == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic tx_byte(input int idx, input logic [7:0] d);
    int n;
    if (idx == 0) begin req0_data = d; req0_valid = 1'b1; end
    else          begin req1_data = d; req1_valid = 1'b1; end
    n = 0;
    while (!rdy_of(idx) && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("tx_grant_timeout", (n < 200), 1'b1);
    @(posedge CLK); #1;   // transfer completes on this edge
    if (idx == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic pe, input logic fe);
    int n;
    int base;
    base = n_reads;
    uart_rdata = d; uart_perr = pe; uart_ferr = fe; uart_rxrdy = 1'b1;
    n = 0;
    while (n_reads == base && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("rx_read_timeout", (n < 200), 1'b1);
    uart_rxrdy = 1'b0;
  endtask

  task automatic push_tx(input logic idx, input logic [7:0] d);
    tx_exp_t e;
    e.idx = idx; e.d = d;
    tx_q.push_back(e);
  endtask

  task automatic push_rx(input logic [7:0] d, input logic pe, input logic fe);
    rx_exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    rx_q.push_back(e);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_csn"}, uart_csn, 1'b1);
    chk({p, "_wen"}, uart_wen, 1'b1);
    chk({p, "_oen"}, uart_oen, 1'b1);
    chk({p, "_wdata"}, uart_wdata, 8'h00);
    chk({p, "_ready"}, {req1_ready, req0_ready}, 2'b00);
    chk({p, "_rx_valid"}, rx_valid, 1'b0);
    chk({p, "_rx_data"}, rx_data, 8'h00);
    chk({p, "_rx_flags"}, {rx_perr, rx_ferr}, 2'b00);
    chk({p, "_err_ovf"}, err_overflow, 1'b0);
    chk({p, "_tx_count"}, tx_count, 16'd0);
    chk({p, "_rx_count"}, rx_count, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] a_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] b_bytes [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};

  initial begin
    int n;
    req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
    rx_ready = 1; err_clr = 0;
    uart_rdata = 0; uart_txrdy = 0; uart_rxrdy = 0;
    uart_perr = 0; uart_ferr = 0; uart_ovf = 0;
    RESET_N = 0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset("reset");
    RESET_N = 1;
    repeat (2) @(posedge CLK);
    #1;
    uart_txrdy = 1;

    // Single byte from req0.
    push_tx(1'b0, 8'h55);
    tx_byte(0, 8'h55);
    repeat (4) @(posedge CLK);
    #1;
    chk("t1_tx_count", tx_count, 16'd1);
    chk("t1_tx_drained", tx_q.size(), 0);

    // Both requesters, 4 bytes each. The previous grant went to req0, so the
    // pointer now favours req1 and grants alternate 1,0,1,0...
    strobe_cyc.delete(); strobe_kind.delete();
    for (int i = 0; i < 4; i++) begin
      push_tx(1'b1, b_bytes[i]);
      push_tx(1'b0, a_bytes[i]);
    end
    fork
      begin for (int i = 0; i < 4; i++) tx_byte(0, a_bytes[i]); end
      begin for (int j = 0; j < 4; j++) tx_byte(1, b_bytes[j]); end
    join
    repeat (6) @(posedge CLK);
    #1;
    chk("t2_tx_count", tx_count, 16'd9);
    chk("t2_tx_drained", tx_q.size(), 0);
    chk("t2_n_writes", strobe_cyc.size(), 8);
    // Continuous traffic: WRITE, G guard cycles, one IDLE -> G+2 apart.
    for (int k = 1; k < strobe_cyc.size(); k++)
      chk("t2_write_period", strobe_cyc[k] - strobe_cyc[k-1], G + 2);

    // RX and TX ready in the same cycle: READ must go first.
    strobe_cyc.delete(); strobe_kind.delete();
    push_rx(8'hA3, 1'b0, 1'b0);
    push_tx(1'b0, 8'h3C);
    fork
      rx_byte(8'hA3, 1'b0, 1'b0);
      tx_byte(0, 8'h3C);
    join
    repeat (6) @(posedge CLK);
    #1;
    chk("t3_n_strobes", strobe_kind.size(), 2);
    if (strobe_kind.size() == 2) begin
      chk("t3_first_is_read", strobe_kind[0], 2);
      chk("t3_second_is_write", strobe_kind[1], 1);
    end
    chk("t3_rx_count", rx_count, 16'd1);
    chk("t3_tx_count", tx_count, 16'd10);

    // Stalled RX stream with rxrdy held: exactly one READ, data held.
    rx_ready = 0;
    push_rx(8'h5A, 1'b0, 1'b0);
    n = n_reads;
    uart_rdata = 8'h5A; uart_rxrdy = 1;
    repeat (5) @(posedge CLK);
    #1;
    uart_rdata = 8'hFF;   // must not disturb the held byte
    repeat (15) @(posedge CLK);
    #1;
    chk("t4_single_read", n_reads - n, 1);
    chk("t4_rx_valid_held", rx_valid, 1'b1);
    chk("t4_rx_data_held", rx_data, 8'h5A);
    uart_rxrdy = 0;
    @(posedge CLK); #1;
    rx_ready = 1;
    repeat (4) @(posedge CLK);
    #1;
    chk("t4_rx_valid_dropped", rx_valid, 1'b0);
    chk("t4_rx_count", rx_count, 16'd2);
    chk("t4_rx_drained", rx_q.size(), 0);

    // Sticky overflow: set wins over clear, holds without clear, then clears.
    chk("t5_err_before", err_overflow, 1'b0);
    uart_ovf = 1; err_clr = 1;
    @(posedge CLK); #1;
    chk("t5_set_wins", err_overflow, 1'b1);
    uart_ovf = 0; err_clr = 0;
    @(posedge CLK); #1;
    chk("t5_sticky", err_overflow, 1'b1);
    err_clr = 1;
    @(posedge CLK); #1;
    chk("t5_cleared", err_overflow, 1'b0);
    err_clr = 0;

    // Parity and framing flags travel with their byte.
    push_rx(8'hC7, 1'b1, 1'b0);
    rx_byte(8'hC7, 1'b1, 1'b0);
    push_rx(8'h81, 1'b0, 1'b1);
    rx_byte(8'h81, 1'b0, 1'b1);
    uart_perr = 0; uart_ferr = 0;
    repeat (6) @(posedge CLK);
    #1;
    chk("t6_rx_count", rx_count, 16'd4);
    chk("t6_rx_drained", rx_q.size(), 0);

    // Reset in the middle of a READ: no byte may be delivered.
    uart_rdata = 8'h99; uart_rxrdy = 1;
    n = 0;
    while (uart_oen && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("t7_read_seen", uart_oen, 1'b0);
    #2;
    RESET_N = 0;
    #1;
    check_reset("t7_mid_read");
    uart_rxrdy = 0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1;
    repeat (6) @(posedge CLK);
    #1;
    chk("t7_no_rx_after", rx_valid, 1'b0);
    chk("t7_rx_count", rx_count, 16'd0);
    chk("t7_rx_q_empty", rx_q.size(), 0);
    chk("t7_tx_q_empty", tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
